instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch_buffer.sv | 106 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer and its queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries; flush empties it in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    output fetch_entry_t             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (do_push && !flush) mem_d[wptr_q] = wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch: issues in-order word fetches, queues responses and
// presents the head to the datapath; redirects flush and refetch.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        InstrValidF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, last_pc_q, last_pc_d;
    logic [CW-1:0] outst_q, outst_d, fifo_count;
    logic [CW:0]   inflight;
    logic          grant, rsp_live, push, pop, fifo_empty;
    fetch_entry_t  head, new_entry;

    // Responses with nothing outstanding are leftovers from before a reset.
    assign grant     = imem_req && imem_gnt;
    assign rsp_live  = imem_rvalid && (outst_q != '0);
    assign push      = rsp_live && (state_q == RUN) && !redirect;
    assign pop       = InstrValidF && !stall && !redirect;
    assign inflight  = {1'b0, fifo_count} + {1'b0, outst_q};
    assign outst_d   = outst_q + CW'(grant) - CW'(rsp_live);
    assign new_entry = '{pc: rsp_pc_q, instr: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .wdata (new_entry),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!redirect && start) state_d = RUN;
            RUN:     if (redirect && outst_d != '0) state_d = FLUSH;
            FLUSH:   if (!redirect && outst_d == '0) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state_q == RUN) && start && !redirect && (inflight < (CW+1)'(DEPTH));
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        last_pc_d  = InstrValidF ? head.pc : last_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            rsp_pc_d   = redirect_pc & ~32'h3;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  rsp_pc_d   = rsp_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
            outst_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            last_pc_q  <= last_pc_d;
            outst_q    <= outst_d;
        end
    end

    assign InstrValidF = !fifo_empty;
    assign InstrF      = InstrValidF ? head.instr : NOP_INSTR;
    assign PCF         = InstrValidF ? head.pc : last_pc_q;
    assign imem_addr   = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Phase table of held inputs with end-of-phase expectations, plus a memory
// model and in-order scoreboard checked every cycle.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset, start, redirect, stall, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic [31:0] InstrF, PCF, imem_addr;
    logic        InstrValidF, imem_req;

    always #5 clk = ~clk;

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .InstrValidF (InstrValidF),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata)
    );

    typedef struct {
        bit          rst, st, stl, rd;
        logic [31:0] rpc;
        bit          gnt, rsp;
        int          n;
        bit          chk, ev, ereq, cpc, caddr;
        logic [31:0] epc, eaddr;
    } vec_t;

    vec_t         tbl[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  pend_q[$];
    logic [31:0]  exp_fetch;
    int           errors = 0, checks = 0, drop_cnt = 0, stray_cnt = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic vec_t mk(input bit rst, st, stl, rd, input logic [31:0] rpc,
                                input bit gnt, rsp, input int n, input bit chk, ev, ereq,
                                cpc, input logic [31:0] epc, input bit caddr,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.rd = rd; v.rpc = rpc;
        v.gnt = gnt; v.rsp = rsp; v.n = n; v.chk = chk; v.ev = ev; v.ereq = ereq;
        v.cpc = cpc; v.epc = epc; v.caddr = caddr; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit last);
        bit          rsp_now;
        logic [31:0] rsp_a;
        fetch_entry_t e;
        reset = v.rst; start = v.st; stall = v.stl; redirect = v.rd;
        redirect_pc = v.rpc; imem_gnt = v.gnt;
        imem_rvalid = 1'b0; imem_rdata = '0; rsp_now = 1'b0; rsp_a = '0;
        if (v.rsp && pend_q.size() > 0) begin
            rsp_a = pend_q.pop_front();
            rsp_now = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata = memf(rsp_a);
        end
        @(negedge clk);
        if (last && v.chk) begin
            check32("phase_valid", InstrValidF, v.ev);
            check32("phase_req", imem_req, v.ereq);
            if (v.cpc)   check32("phase_pcf", PCF, v.epc);
            if (v.caddr) check32("phase_addr", imem_addr, v.eaddr);
        end
        if (v.rst) begin
            check32("rst_valid", InstrValidF, 1'b0);
            check32("rst_req", imem_req, 1'b0);
            check32("rst_instr", InstrF, NOP_INSTR);
            check32("rst_pcf", PCF, RESET_PC);
            exp_q.delete();
            drop_cnt  = 0;
            stray_cnt = pend_q.size();
            exp_fetch = RESET_PC;
        end else begin
            check32("valid_vs_model", InstrValidF, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check32("head_pc", PCF, exp_q[0].pc);
                check32("head_instr", InstrF, exp_q[0].instr);
                if (!v.stl && !v.rd) void'(exp_q.pop_front());
            end else begin
                check32("empty_nop", InstrF, NOP_INSTR);
            end
            if (imem_req) check32("req_addr", imem_addr, exp_fetch);
            if (v.rd) begin
                exp_q.delete();
                drop_cnt  = pend_q.size() - stray_cnt;
                exp_fetch = v.rpc & ~32'h3;
            end else if (rsp_now) begin
                if (stray_cnt > 0)     stray_cnt--;
                else if (drop_cnt > 0) drop_cnt--;
                else begin
                    e.pc = rsp_a; e.instr = memf(rsp_a);
                    exp_q.push_back(e);
                end
            end
            if (imem_req && imem_gnt) begin
                pend_q.push_back(imem_addr);
                exp_fetch += 32'd4;
            end
            checks++;
            if ((pend_q.size() - stray_cnt) + exp_q.size() > DEPTH) begin
                errors++;
                $display("FAIL occupancy: got %0d expected <= %0d",
                         (pend_q.size() - stray_cnt) + exp_q.size(), DEPTH);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; exp_fetch = RESET_PC;
        //           rst st stl rd rpc           gnt rsp n  chk ev req cpc epc           caddr eaddr
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 3, 1, 0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 0, 32'h0,        1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 1, 1, 1, 32'h0,        1, 32'h8));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 8, 1, 1, 1, 1, 32'h20,       1, 32'h28));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1,10, 1, 1, 0, 1, 32'h24,       0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 6, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 8, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 2, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h100,      1, 0, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 5, 1, 1, 1, 1, 32'h100,      1, 32'h108));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 8, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 3, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h180,      1, 0, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h200,      1, 0, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h300,      1, 1, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 5, 1, 1, 1, 1, 32'h300,      1, 32'h308));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 8, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 32'hFFFFFFFC, 1, 1, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 0, 32'h0,        1, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 0, 32'h0,        1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 1, 1, 1, 32'hFFFFFFFC, 1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 1, 1, 1, 1, 1, 32'h0,        1, 32'h8));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 8, 1, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 3, 0, 0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 2, 1, 0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 4, 1, 0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 4, 1, 1, 1, 1, 32'h0,        1, 32'h8));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 2, 1, 0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h40,       1, 0, 1, 1, 0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 4, 1, 1, 1, 1, 32'h40,       1, 32'h48));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) run_cycle(tbl[i], c == tbl[i].n - 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
